clock_divider_prog: RTL and testbench

//   Multi-channel, runtime-programmable clock divider for the motor PWM path.

---
 rtl/clkdiv_pkg.sv | 13 +
 rtl/clkdiv_if.sv | 12 +
 rtl/clkdiv_channel.sv | 94 +++++++++
 rtl/clock_divider_prog.sv | 54 +++++
 tb/tb_clock_divider_prog.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clkdiv_pkg;

  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned RST_HALF_DEF = 50;
  localparam int unsigned HALF_STOP    = 0;

  // Channel-index width, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clkdiv_if.sv
// Half-period write port shared by all divider channels.
interface clkdiv_if #(
  parameter int unsigned CH_W  = 2,
  parameter int unsigned CNT_W = 16
);
  logic             wr;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_half;

  modport master (output wr, wr_ch, wr_half);
  modport slave  (input  wr, wr_ch, wr_half);
endinterface

// File: rtl/clkdiv_channel.sv
// One divider channel: half-period counter, active/shadow HALF and registered outputs.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned RST_HALF = RST_HALF_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_half_i,
  input  logic             sync_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             pending_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] new_half;
  logic             wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= CNT_W'(RST_HALF);
      shadow_q <= CNT_W'(RST_HALF);
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      pend_q   <= pend_d;
    end
  end

  // A write landing on the apply edge is taken directly (write-through).
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    shadow_d = shadow_q;
    clk_d    = clk_q;
    tick_d   = 1'b0;
    pend_d   = pend_q;
    new_half = wr_i ? wr_half_i : shadow_q;
    wrap     = (cnt_q == active_q - CNT_W'(1));

    if (wr_i) begin
      shadow_d = wr_half_i;
      pend_d   = 1'b1;
    end

    if (sync_i) begin
      cnt_d    = '0;
      clk_d    = 1'b0;
      active_d = new_half;
      pend_d   = 1'b0;
    end else if (active_q == CNT_W'(HALF_STOP)) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (pend_q) begin
        active_d = new_half;
        pend_d   = 1'b0;
      end
    end else if (en_i) begin
      if (wrap) begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        tick_d = ~clk_q;
        // Falling edge closes the full period: safe point to swap HALF.
        if (clk_q) begin
          active_d = new_half;
          pend_d   = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign clk_o     = clk_q;
  assign tick_o    = tick_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/clock_divider_prog.sv
// Multi-channel runtime-programmable clock divider for the motor PWM timebases.
// Define CLKDIV_SYNC_EN to add the i_sync input that phase-aligns all channels.
module clock_divider_prog
  import clkdiv_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned RST_HALF = RST_HALF_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NUM_CH-1:0] i_en,
  clkdiv_if.slave           wr_if,
`ifdef CLKDIV_SYNC_EN
  input  logic              i_sync,
`endif
  output logic [NUM_CH-1:0] o_clk,
  output logic [NUM_CH-1:0] o_tick,
  output logic [NUM_CH-1:0] o_pending
);

  localparam int unsigned CH_W = clog2_min1(NUM_CH);

  logic sync;

`ifdef CLKDIV_SYNC_EN
  assign sync = i_sync;
`else
  assign sync = 1'b0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic wr_sel;

    // Out-of-range channel indices match no channel and are dropped.
    assign wr_sel = wr_if.wr && (wr_if.wr_ch == CH_W'(c));

    clkdiv_channel #(
      .CNT_W    (CNT_W),
      .RST_HALF (RST_HALF)
    ) u_ch (
      .clk       (i_clk),
      .rst_n     (i_reset_n),
      .en_i      (i_en[c]),
      .wr_i      (wr_sel),
      .wr_half_i (wr_if.wr_half),
      .sync_i    (sync),
      .clk_o     (o_clk[c]),
      .tick_o    (o_tick[c]),
      .pending_o (o_pending[c])
    );
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed self-checking bench for clock_divider_prog; edges counted from reset release.
module tb_clock_divider_prog;

  logic       clk;
  logic       rst_n;
  logic [3:0] en;
  logic [2:0] en3;
  logic [3:0] o_clk, o_tick, o_pend;
  logic [2:0] o_clk3, o_tick3, o_pend3;
  int         n_chk;
  int         n_fail;
  int         edge_n;
`ifdef CLKDIV_SYNC_EN
  logic       sync;
  logic       sync3;
`endif

  clkdiv_if #(.CH_W(2), .CNT_W(16)) wr_if ();
  clkdiv_if #(.CH_W(2), .CNT_W(16)) wr3_if ();

  clock_divider_prog #(.NUM_CH(4), .CNT_W(16), .RST_HALF(50)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_en      (en),
    .wr_if     (wr_if),
`ifdef CLKDIV_SYNC_EN
    .i_sync    (sync),
`endif
    .o_clk     (o_clk),
    .o_tick    (o_tick),
    .o_pending (o_pend)
  );

  // Three-channel instance so that index 3 is out of range.
  clock_divider_prog #(.NUM_CH(3), .CNT_W(16), .RST_HALF(50)) dut3 (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_en      (en3),
    .wr_if     (wr3_if),
`ifdef CLKDIV_SYNC_EN
    .i_sync    (sync3),
`endif
    .o_clk     (o_clk3),
    .o_tick    (o_tick3),
    .o_pending (o_pend3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after rising edge number e.
  task automatic go(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [15:0] half);
    wr_if.wr      = 1'b1;
    wr_if.wr_ch   = ch;
    wr_if.wr_half = half;
    go(edge_n + 1);
    wr_if.wr      = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    edge_n = 0;
    rst_n  = 1'b0;
    en     = 4'hF;
    en3    = 3'h7;
    wr_if.wr = 1'b0;  wr_if.wr_ch = '0;  wr_if.wr_half = '0;
    wr3_if.wr = 1'b0; wr3_if.wr_ch = '0; wr3_if.wr_half = '0;
`ifdef CLKDIV_SYNC_EN
    sync  = 1'b0;
    sync3 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk",  32'(o_clk),  32'h0);
    check("rst_tick", 32'(o_tick), 32'h0);
    check("rst_pend", 32'(o_pend), 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;

    // Default HALF=50: first rise at edge 50, period 100
    go(49);  check("t1_clk_e49",  32'(o_clk),  32'h0);
    go(50);  check("t1_clk_e50",  32'(o_clk),  32'hF);
             check("t1_tick_e50", 32'(o_tick), 32'hF);
    go(51);  check("t1_tick_e51", 32'(o_tick), 32'h0);
             check("t1_clk_e51",  32'(o_clk),  32'hF);

    // ch1 HALF=3 written in the high phase
    go(60);  do_write(2'd1, 16'd3);
             check("t2_pend_e61", 32'(o_pend[1]), 32'h1);
    go(99);  check("t2_clk_e99",  32'(o_clk[1]), 32'h1);
             check("t2_pend_e99", 32'(o_pend[1]), 32'h1);
    go(100); check("t2_clk_e100",  32'(o_clk[1]), 32'h0);
             check("t2_pend_e100", 32'(o_pend[1]), 32'h0);
    go(102); check("t2_clk_e102",  32'(o_clk[1]), 32'h0);
    go(103); check("t2_clk_e103",  32'(o_clk[1]), 32'h1);
             check("t2_tick_e103", 32'(o_tick[1]), 32'h1);
    go(104); check("t2_tick_e104", 32'(o_tick[1]), 32'h0);
    go(106); check("t2_clk_e106",  32'(o_clk[1]), 32'h0);
    go(109); check("t2_clk_e109",  32'(o_clk[1]), 32'h1);
             check("t2_tick_e109", 32'(o_tick[1]), 32'h1);

    // ch2 stop at period end, then restart with HALF=5
    go(119); do_write(2'd2, 16'd0);
    go(199); check("t3_clk_e199",  32'(o_clk[2]), 32'h1);
             check("t3_pend_e199", 32'(o_pend[2]), 32'h1);
    go(200); check("t3_clk_e200",  32'(o_clk[2]), 32'h0);
             check("t3_pend_e200", 32'(o_pend[2]), 32'h0);
    go(250); check("t3_stopped_e250", 32'(o_clk[2]), 32'h0);
             check("t3_notick_e250",  32'(o_tick[2]), 32'h0);
    do_write(2'd2, 16'd5);
             check("t3_pend_e251", 32'(o_pend[2]), 32'h1);
    go(252); check("t3_pend_e252", 32'(o_pend[2]), 32'h0);
    go(256); check("t3_clk_e256",  32'(o_clk[2]), 32'h0);
    go(257); check("t3_clk_e257",  32'(o_clk[2]), 32'h1);
             check("t3_tick_e257", 32'(o_tick[2]), 32'h1);

    // ch0 back-to-back writes 10 then 20: 20 applied at edge 300
    go(260);
    wr_if.wr = 1'b1; wr_if.wr_ch = 2'd0; wr_if.wr_half = 16'd10;
    go(261);
    wr_if.wr_half = 16'd20;
    go(262);
    wr_if.wr = 1'b0;
             check("t4_pend_e262", 32'(o_pend[0]), 32'h1);
    go(263);
    wr3_if.wr = 1'b1; wr3_if.wr_ch = 2'd3; wr3_if.wr_half = 16'd7;
    go(264);
    wr3_if.wr = 1'b0;
             check("t4_oor_pend", 32'(o_pend3), 32'h0);
    go(300); check("t4_clk_e300",  32'(o_clk[0]), 32'h0);
             check("t4_pend_e300", 32'(o_pend[0]), 32'h0);
             check("t4_oor_clk_e300", 32'(o_clk3), 32'h0);
    go(310); check("t4_clk_e310", 32'(o_clk[0]), 32'h0);
    go(319); check("t4_clk_e319", 32'(o_clk[0]), 32'h0);
    go(320); check("t4_clk_e320", 32'(o_clk[0]), 32'h1);
             check("t4_tick_e320", 32'(o_tick[0]), 32'h1);
    go(339); check("t4_clk_e339", 32'(o_clk[0]), 32'h1);
    go(340); check("t4_clk_e340", 32'(o_clk[0]), 32'h0);
    go(350); check("t4_oor_clk_e350",  32'(o_clk3),  32'h7);
             check("t4_oor_tick_e350", 32'(o_tick3), 32'h7);

    // ch3 disabled for 37 edges (421..457) in the low phase
    go(420); en[3] = 1'b0;
    go(450); check("t5_clk_e450",  32'(o_clk[3]), 32'h0);
             check("t5_tick_e450", 32'(o_tick[3]), 32'h0);
    go(457); en[3] = 1'b1;
    go(486); check("t5_clk_e486",  32'(o_clk[3]), 32'h0);
    go(487); check("t5_clk_e487",  32'(o_clk[3]), 32'h1);
             check("t5_tick_e487", 32'(o_tick[3]), 32'h1);
    go(536); check("t5_clk_e536",  32'(o_clk[3]), 32'h1);
    go(537); check("t5_clk_e537",  32'(o_clk[3]), 32'h0);

`ifdef CLKDIV_SYNC_EN
    go(540);
    do_write(2'd0, 16'd50);
    do_write(2'd1, 16'd25);
    do_write(2'd2, 16'd10);
    do_write(2'd3, 16'd1);
    sync = 1'b1;
    go(545);
    sync = 1'b0;
             check("t6_clk_e545",  32'(o_clk),  32'h0);
             check("t6_pend_e545", 32'(o_pend), 32'h0);
    go(546); check("t6_clk3_e546", 32'(o_clk[3]), 32'h1);
             check("t6_lo_e546",   32'(o_clk[2:0]), 32'h0);
    go(554); check("t6_clk2_e554", 32'(o_clk[2]), 32'h0);
    go(555); check("t6_clk2_e555", 32'(o_clk[2]), 32'h1);
    go(569); check("t6_clk1_e569", 32'(o_clk[1]), 32'h0);
    go(570); check("t6_clk1_e570", 32'(o_clk[1]), 32'h1);
    go(594); check("t6_clk0_e594", 32'(o_clk[0]), 32'h0);
    go(595); check("t6_clk0_e595", 32'(o_clk[0]), 32'h1);
`endif

    // Async reset between edges drops outputs and the pending write
    go(599); do_write(2'd1, 16'd9);
             check("t7_pend_before", 32'(o_pend[1]), 32'h1);
    go(610);
`ifndef CLKDIV_SYNC_EN
             check("t7_high_before", 32'(o_clk[3]), 32'h1);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_clk",  32'(o_clk),  32'h0);
    check("t7_tick", 32'(o_tick), 32'h0);
    check("t7_pend", 32'(o_pend), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
